// File: rtl/video_sync_gen_if.sv
// Raster timing bundle carried from the sync generator to downstream pixel/sprite stages.
// The generator drives it through the master modport and consumers read it through the slave modport.
interface video_sync_gen_if #(
    parameter int unsigned CNT_W = 9
);
    logic             pix_en;
    logic [CNT_W-1:0] hpos;
    logic [CNT_W-1:0] vpos;
    logic             hsync;
    logic             vsync;
    logic             display_on;
    logic             line_start;
    logic             frame_start;
    logic [7:0]       frame_count;

    modport master (
        output pix_en,
        output hpos,
        output vpos,
        output hsync,
        output vsync,
        output display_on,
        output line_start,
        output frame_start,
        output frame_count
    );

    modport slave (
        input pix_en,
        input hpos,
        input vpos,
        input hsync,
        input vsync,
        input display_on,
        input line_start,
        input frame_start,
        input frame_count
    );
endinterface

// File: rtl/video_sync_gen.sv
// Raster timing generator: beam position, glitch-free sync, active-area flag,
// line/frame pulses and a frame counter, advanced once per pixel tick.
module video_sync_gen #(
    parameter int unsigned H_DISPLAY = 256,
    parameter int unsigned H_FRONT   = 7,
    parameter int unsigned H_SYNC    = 23,
    parameter int unsigned H_BACK    = 23,
    parameter int unsigned V_DISPLAY = 240,
    parameter int unsigned V_BOTTOM  = 14,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_TOP     = 5,
    parameter bit          SYNC_POL  = 1'b1,
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned CNT_W     = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    video_sync_gen_if.master     vid
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_DISPLAY);

    // Sync windows are inclusive [start, end].
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_DISPLAY + V_BOTTOM);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] hpos_q, hpos_d;
    logic [CNT_W-1:0] vpos_q, vpos_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             line_start_q;
    logic             frame_start_q;
    logic [7:0]       frame_count_q;
    logic             pix_en;
    logic             h_wrap;
    logic             v_wrap;

    always_comb begin
        pix_en = (div_q == DIV_LAST);
        div_d  = pix_en ? '0 : div_q + DIV_W'(1);
        h_wrap = pix_en && (hpos_q == H_LAST);
        v_wrap = h_wrap && (vpos_q == V_LAST);

        hpos_d = hpos_q;
        vpos_d = vpos_q;
        if (pix_en) begin
            hpos_d = h_wrap ? '0 : hpos_q + CNT_W'(1);
        end
        if (h_wrap) begin
            vpos_d = v_wrap ? '0 : vpos_q + CNT_W'(1);
        end

        // Decoded from the next-state position so the registered sync lines up with hpos/vpos.
        hsync_d = ((hpos_d >= H_SYNC_START) && (hpos_d <= H_SYNC_END)) ? SYNC_POL : !SYNC_POL;
        vsync_d = ((vpos_d >= V_SYNC_START) && (vpos_d <= V_SYNC_END)) ? SYNC_POL : !SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            hsync_q       <= !SYNC_POL;
            vsync_q       <= !SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            div_q         <= div_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (v_wrap) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
        end
    end

    assign vid.pix_en      = pix_en;
    assign vid.hpos        = hpos_q;
    assign vid.vpos        = vpos_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.display_on  = (hpos_q < H_ACT) && (vpos_q < V_ACT) && !reset;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_count = frame_count_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: four instances (default timing, a reduced raster at CLK_DIV=2,
// the reduced raster at CLK_DIV=1, and default timing with a mid-frame reset) scored every cycle.
module tb_video_sync_gen;

    typedef struct packed {
        logic       pix_en;
        logic [8:0] hpos;
        logic [8:0] vpos;
        logic       hsync;
        logic       vsync;
        logic       display_on;
        logic       line_start;
        logic       frame_start;
        logic [7:0] frame_count;
    } obs_t;

    typedef struct {
        int   id;
        obs_t exp;
    } sb_t;

    localparam int NDUT    = 4;
    localparam int RUN_CLK = 80970;

    logic             clk = 1'b0;
    logic [NDUT-1:0]  rst_v;
    int               t [NDUT];
    int               passed = 0;
    int               total  = 0;
    sb_t              sb_q [$];
    bit               b_done = 1'b0;
    bit               d_done = 1'b0;

    always #5 clk = ~clk;

    video_sync_gen_if #(.CNT_W(9)) vif_a ();
    video_sync_gen_if #(.CNT_W(9)) vif_b ();
    video_sync_gen_if #(.CNT_W(9)) vif_c ();
    video_sync_gen_if #(.CNT_W(9)) vif_d ();

    video_sync_gen dut_a (.clk(clk), .reset(rst_v[0]), .vid(vif_a));

    video_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2),
        .SYNC_POL(1'b1), .CLK_DIV(2), .CNT_W(9)
    ) dut_b (.clk(clk), .reset(rst_v[1]), .vid(vif_b));

    video_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2),
        .SYNC_POL(1'b1), .CLK_DIV(1), .CNT_W(9)
    ) dut_c (.clk(clk), .reset(rst_v[2]), .vid(vif_c));

    video_sync_gen dut_d (.clk(clk), .reset(rst_v[3]), .vid(vif_d));

    // Expected outputs from elapsed clocks since reset release, computed arithmetically.
    function automatic obs_t model(input int id, input bit in_rst, input int tt);
        int d, hd, hf, hs, hb, vd, vb, vs, vtp, ht, vt, p, hp, vp;
        bit first;
        obs_t e;
        if (id == 1 || id == 2) begin
            hd = 8;   hf = 2;  hs = 3;  hb = 2;  vd = 6;   vb = 2;  vs = 2; vtp = 2;
        end else begin
            hd = 256; hf = 7;  hs = 23; hb = 23; vd = 240; vb = 14; vs = 3; vtp = 5;
        end
        d  = (id == 1) ? 2 : 1;
        ht = hd + hf + hs + hb;
        vt = vd + vb + vs + vtp;
        e  = '0;
        if (in_rst) begin
            e.pix_en = (d == 1);
        end else begin
            p     = tt / d;
            hp    = p % ht;
            vp    = (p / ht) % vt;
            first = ((tt % d) == 0) && (p > 0);
            e.pix_en      = ((tt % d) == d - 1);
            e.hpos        = 9'(hp);
            e.vpos        = 9'(vp);
            e.hsync       = (hp >= hd + hf) && (hp < hd + hf + hs);
            e.vsync       = (vp >= vd + vb) && (vp < vd + vb + vs);
            e.display_on  = (hp < hd) && (vp < vd);
            e.line_start  = first && (hp == 0);
            e.frame_start = first && (hp == 0) && (vp == 0);
            e.frame_count = 8'((p / (ht * vt)) % 256);
        end
        return e;
    endfunction

    function automatic obs_t observe(input int id);
        obs_t o;
        case (id)
            0: o = {vif_a.pix_en, vif_a.hpos, vif_a.vpos, vif_a.hsync, vif_a.vsync,
                    vif_a.display_on, vif_a.line_start, vif_a.frame_start, vif_a.frame_count};
            1: o = {vif_b.pix_en, vif_b.hpos, vif_b.vpos, vif_b.hsync, vif_b.vsync,
                    vif_b.display_on, vif_b.line_start, vif_b.frame_start, vif_b.frame_count};
            2: o = {vif_c.pix_en, vif_c.hpos, vif_c.vpos, vif_c.hsync, vif_c.vsync,
                    vif_c.display_on, vif_c.line_start, vif_c.frame_start, vif_c.frame_count};
            default: o = {vif_d.pix_en, vif_d.hpos, vif_d.vpos, vif_d.hsync, vif_d.vsync,
                    vif_d.display_on, vif_d.line_start, vif_d.frame_start, vif_d.frame_count};
        endcase
        return o;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // One clock: advance the model at the edge, queue expectations, score them half a cycle later.
    task automatic cycle();
        sb_t s;
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) begin
            t[i]  = rst_v[i] ? 0 : t[i] + 1;
            s.id  = i;
            s.exp = model(i, rst_v[i], t[i]);
            sb_q.push_back(s);
        end
        @(negedge clk);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            check($sformatf("dut%0d_t%0d_rst%0d", s.id, t[s.id], rst_v[s.id]),
                  observe(s.id), s.exp);
        end
    endtask

    initial begin
        rst_v = '1;
        for (int i = 0; i < NDUT; i++) t[i] = 0;

        repeat (3) cycle();
        check_int("t1_hsync", int'(vif_a.hsync), 0);
        check_int("t1_display_on", int'(vif_a.display_on), 0);

        rst_v = '0;
        #1;
        check("release_a", observe(0), model(0, 1'b0, 0));
        check_int("release_display_on", int'(vif_a.display_on), 1);

        for (int c = 1; c <= RUN_CLK; c++) begin
            cycle();

            if (t[0] == 308) check_int("t2_hpos_last", int'(vif_a.hpos), 308);
            if (t[0] == 309) begin
                check_int("t2_hwrap_hpos", int'(vif_a.hpos), 0);
                check_int("t2_hwrap_vpos", int'(vif_a.vpos), 1);
                check_int("t2_line_start", int'(vif_a.line_start), 1);
            end
            if (t[0] == 80957) check_int("t3_pre_vpos", int'(vif_a.vpos), 261);
            if (t[0] == 80958) begin
                check_int("t3_frame_start", int'(vif_a.frame_start), 1);
                check_int("t3_frame_count", int'(vif_a.frame_count), 1);
            end
            if (t[0] == 80959) check_int("t3_frame_start_drop", int'(vif_a.frame_start), 0);

            if (t[1] == 2) check_int("t4_hpos_two_clk", int'(vif_b.hpos), 1);
            if (t[1] == 360) check_int("t4_frame_start", int'(vif_b.frame_start), 1);

            if (t[2] == 46079) check_int("t6_count_255", int'(vif_c.frame_count), 255);
            if (t[2] == 46080) begin
                check_int("t6_count_wrap", int'(vif_c.frame_count), 0);
                check_int("t6_frame_start", int'(vif_c.frame_start), 1);
            end

            // Mid-line reset on the divided instance while div_cnt is odd.
            if (rst_v[1]) begin
                rst_v[1] = 1'b0;
                b_done   = 1'b1;
            end else if (!b_done && t[1] == 1001) begin
                check_int("t4_pre_rst_pix_en", int'(vif_b.pix_en), 1);
                rst_v[1] = 1'b1;
            end

            if (rst_v[3]) begin
                check_int("t5_rst_hpos", int'(vif_d.hpos), 0);
                check_int("t5_rst_frame_start", int'(vif_d.frame_start), 0);
                rst_v[3] = 1'b0;
                d_done   = 1'b1;
                #1;
                check("t5_release", observe(3), model(3, 1'b0, 0));
            end else if (!d_done && t[3] == 31050) begin
                check_int("t5_pre_hpos", int'(vif_d.hpos), 150);
                check_int("t5_pre_vpos", int'(vif_d.vpos), 100);
                rst_v[3] = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
